// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: owns the PC, issues credit-limited in-order
// requests to instruction memory and buffers returned words toward decode.
package common;
  typedef logic [31:0] instruction_t;
endpackage

module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [31:0]          imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [31:0]          imem_rsp_data,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output common::instruction_t instr,
  output logic [31:0]          instr_pc
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // valid never depends on ready, and once raised the payload holds until taken.
  localparam int              CW       = $clog2(FIFO_DEPTH + 1);
  localparam int              PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW:0]     CREDITS  = (CW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0]   LAST_IDX = PW'(FIFO_DEPTH - 1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] pq_rd_q, pq_rd_d;
  logic [PW-1:0] pq_wr_q, pq_wr_d;

  logic [31:0]   word_q [FIFO_DEPTH];
  logic [31:0]   wpc_q  [FIFO_DEPTH];
  logic [31:0]   pcq_q  [FIFO_DEPTH];

  logic [CW:0]   used;
  logic [31:0]   redirect_aligned;
  logic          req_fire;
  logic          rsp_drop;
  logic          push;
  logic          pop;

  // Credits count both in-flight requests and buffered words, so a response
  // always finds a free FIFO slot and never needs back-pressure.
  assign used             = {1'b0, out_q} + {1'b0, cnt_q};
  assign imem_req_valid   = !rst && (used < CREDITS);
  assign imem_req_addr    = pc_q;
  assign redirect_aligned = redirect_pc & ~32'h3;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_drop = imem_rsp_valid && (drop_q != '0);
  assign push     = imem_rsp_valid && !rsp_drop && !redirect_valid;
  assign pop      = instr_valid && instr_ready;

  assign instr_valid = (cnt_q != '0);
  assign instr       = word_q[rd_ptr_q];
  assign instr_pc    = wpc_q[rd_ptr_q];

  always_comb begin
    pc_d     = pc_q;
    out_d    = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_d   = drop_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    pq_wr_d  = req_fire       ? ptr_inc(pq_wr_q) : pq_wr_q;
    pq_rd_d  = imem_rsp_valid ? ptr_inc(pq_rd_q) : pq_rd_q;

    if (req_fire) begin
      pc_d = pc_q + 32'd4;
    end
    if (rsp_drop) begin
      drop_d = drop_q - CW'(1);
    end

    // Every request still in flight after this edge belongs to the old stream.
    // The PC queue keeps running so its head stays aligned with responses.
    if (redirect_valid) begin
      pc_d     = redirect_aligned;
      drop_d   = out_d;
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      pq_rd_q  <= '0;
      pq_wr_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      pq_rd_q  <= pq_rd_d;
      pq_wr_q  <= pq_wr_d;
    end
  end

  // Storage arrays carry no reset; their contents are qualified by the counters.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pcq_q[pq_wr_q] <= pc_q;
    end
    if (push) begin
      word_q[wr_ptr_q] <= imem_rsp_data;
      wpc_q[wr_ptr_q]  <= pcq_q[pq_rd_q];
    end
  end

  a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (out_q != '0));

  a_push_has_room: assert property (@(posedge clk) disable iff (rst)
    push |-> ((cnt_q != CW'(FIFO_DEPTH)) || pop));

  a_drop_bounded: assert property (@(posedge clk) disable iff (rst)
    drop_q <= out_q);

endmodule
